truth_table_sweeper: RTL and testbench

- Drives a 4-input single-output combinational network through all 16 input configurations, x = 0 to 15.
- After a settle window per configuration, samples the network output z and builds its 16-bit truth table.
- Counts the minterms (ones) and compares the captured table against an expected function.
- Sits on the driving side of the network's x3..x0 / z interface. Used as a self-checking collaudo unit for the two-level SdP networks.

---
 rtl/truth_table_sweeper.sv | 119 +++++++++++
 tb/tb_truth_table_sweeper.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps x=0..15 into a 4-in/1-out network,
// captures its truth table, counts ones and checks it against EXPECTED.
//   clock, reset_  : rising-edge clock, async active-low reset
//   start          : sweep request, taken only when idle
//   x3..x0         : registered drive lines (x3 = MSB)
//   z              : network output, sampled after SETTLE extra cycles
//   busy, done     : sweep in progress / one-cycle completion pulse
//   truth_table    : captured table, bit i = z at x=i
//   ones           : number of ones in truth_table (0..16)
//   match          : truth_table == EXPECTED, valid from done onward
//   mismatch_valid : some bit differs; first_mismatch = lowest such index
// The table port is named truth_table because "table" is a reserved word.
module truth_table_sweeper #(
  parameter logic [3:0]  SETTLE   = 4'd2,
  parameter logic [15:0] EXPECTED = 16'hA7F7
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        start,
  output logic        x3,
  output logic        x2,
  output logic        x1,
  output logic        x0,
  input  logic        z,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  ones,
  output logic        match,
  output logic        mismatch_valid,
  output logic [3:0]  first_mismatch
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [3:0]  x;
  logic [15:0] tbl_next;

  assign {x3, x2, x1, x0} = x;

  // table including the sample taken at this edge; feeds match on the last one
  always_comb begin
    tbl_next      = truth_table;
    tbl_next[idx] = z;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      x              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      truth_table    <= '0;
      ones           <= '0;
      match          <= 1'b0;
      mismatch_valid <= 1'b0;
      first_mismatch <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          x    <= '0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state          <= WAIT;
            busy           <= 1'b1;
            idx            <= '0;
            cnt            <= '0;
            truth_table    <= '0;
            ones           <= '0;
            match          <= 1'b0;
            mismatch_valid <= 1'b0;
            first_mismatch <= '0;
          end
        end
        WAIT: begin
          if (cnt < SETTLE) begin
            cnt <= cnt + 4'd1;
          end else begin
            truth_table <= tbl_next;
            ones        <= ones + {4'd0, z};
            if ((z != EXPECTED[idx]) && !mismatch_valid) begin
              mismatch_valid <= 1'b1;
              first_mismatch <= idx;
            end
            if (idx == 4'd15) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              match <= (tbl_next == EXPECTED);
            end else begin
              idx <= idx + 4'd1;
              x   <= idx + 4'd1;
              cnt <= '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          x     <= '0;
          idx   <= '0;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: three sweepers (SETTLE 2, 0, 1) driving modelled
// networks, checked every cycle against a timeline model plus literal results.
module tb_truth_table_sweeper;

  localparam logic [15:0] EXP = 16'hA7F7;

  logic        clock;
  logic        reset_;
  logic        start [3];
  logic [3:0]  xv    [3];
  logic        zw    [3];
  logic        zd    [3];
  logic        busy  [3];
  logic        done  [3];
  logic [15:0] tt    [3];
  logic [4:0]  ones  [3];
  logic        match [3];
  logic        mv    [3];
  logic [3:0]  fm    [3];
  logic [15:0] fn    [3];
  logic        dl    [3];

  int n_cmp = 0;
  int n_err = 0;

  function automatic int settle_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 1;
  endfunction

  function automatic logic [15:0] golden();
    logic [15:0] g;
    for (int i = 0; i < 16; i++)
      g[i] = !(i == 3 || i == 11 || i == 12 || i == 14);
    return g;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [3:0] SG = (g == 0) ? 4'd2 : (g == 1) ? 4'd0 : 4'd1;
    truth_table_sweeper #(.SETTLE(SG), .EXPECTED(EXP)) u_dut (
      .clock          (clock),
      .reset_         (reset_),
      .start          (start[g]),
      .x3             (xv[g][3]),
      .x2             (xv[g][2]),
      .x1             (xv[g][1]),
      .x0             (xv[g][0]),
      .z              (zw[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .truth_table    (tt[g]),
      .ones           (ones[g]),
      .match          (match[g]),
      .mismatch_valid (mv[g]),
      .first_mismatch (fm[g])
    );
    // network: combinational table lookup, optionally one cycle late
    assign zw[g] = dl[g] ? zd[g] : fn[g][xv[g]];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock)
    for (int k = 0; k < 3; k++) zd[k] <= fn[k][xv[k]];

  // timeline model: phase 0 idle, 1 sweeping, 2 done; t = cycles since start
  int          m_ph  [3];
  int          m_t   [3];
  int          m_n   [3];
  logic [15:0] m_tab [3];
  logic        m_mat [3];

  always @(posedge clock or negedge reset_) begin
    int p;
    int t;
    logic [15:0] nt;
    if (!reset_) begin
      for (int k = 0; k < 3; k++) begin
        m_ph[k]  <= 0;
        m_t[k]   <= 0;
        m_n[k]   <= 0;
        m_tab[k] <= '0;
        m_mat[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        p = settle_of(k) + 1;
        if (m_ph[k] == 0) begin
          if (start[k]) begin
            m_ph[k]  <= 1;
            m_t[k]   <= 0;
            m_n[k]   <= 0;
            m_tab[k] <= '0;
            m_mat[k] <= 1'b0;
          end
        end else if (m_ph[k] == 1) begin
          t = m_t[k] + 1;
          m_t[k] <= t;
          if (t % p == 0) begin
            nt = m_tab[k];
            nt[t / p - 1] = zw[k];
            m_tab[k] <= nt;
            m_n[k]   <= m_n[k] + 1;
            if (t == 16 * p) begin
              m_ph[k]  <= 2;
              m_mat[k] <= (nt == EXP);
            end
          end
        end else begin
          m_ph[k] <= 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [32:0] got;
    logic [32:0] want;
    logic [3:0]  ex;
    logic        emv;
    logic [3:0]  efm;
    for (int k = 0; k < 3; k++) begin
      ex = (m_ph[k] == 1) ? 4'(m_t[k] / (settle_of(k) + 1)) :
           (m_ph[k] == 2) ? 4'd15 : 4'd0;
      emv = 1'b0;
      efm = '0;
      for (int j = 0; j < 16; j++)
        if (j < m_n[k] && !emv && m_tab[k][j] != EXP[j]) begin
          emv = 1'b1;
          efm = 4'(j);
        end
      want = {ex, m_ph[k] == 1, m_ph[k] == 2, m_tab[k],
              5'($countones(m_tab[k])), m_mat[k], emv, efm};
      got  = {xv[k], busy[k], done[k], tt[k], ones[k],
              match[k], mv[k], fm[k]};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL cycle inst%0d at %0t: got %h want %h",
                 k, $time, got, want);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = -1;
    for (int c = 0; c < 400; c++) begin
      if (done[k]) begin
        lat = c;
        break;
      end
      @(negedge clock);
    end
    chk("done_seen", int'(lat >= 0), 1);
  endtask

  task automatic wait_x(input int k, input logic [3:0] v);
    int ok;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (xv[k] == v) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    chk("x_reached", ok, 1);
  endtask

  task automatic sweep(input int k, input logic [15:0] f,
                       input logic d, output int lat);
    fn[k] = f;
    dl[k] = d;
    @(negedge clock);
    start[k] = 1'b1;
    @(negedge clock);
    start[k] = 1'b0;
    wait_done(k, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int k;
    int seen;
    logic [15:0] f;
    reset_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      fn[i]    = '0;
      dl[i]    = 1'b0;
    end
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_x", int'(xv[0]), 0);
    chk("rst_table", int'(tt[0]), 0);
    chk("rst_ones", int'(ones[0]), 0);
    reset_ = 1'b1;

    sweep(0, golden(), 1'b0, lat);
    chk("s1_lat", lat, 48);
    chk("s1_table", int'(tt[0]), 'hA7F7);
    chk("s1_ones", int'(ones[0]), 12);
    chk("s1_match", int'(match[0]), 1);
    chk("s1_mv", int'(mv[0]), 0);

    sweep(0, 16'hFFFF, 1'b0, lat);
    chk("s2_table", int'(tt[0]), 'hFFFF);
    chk("s2_ones", int'(ones[0]), 16);
    chk("s2_match", int'(match[0]), 0);
    chk("s2_mv", int'(mv[0]), 1);
    chk("s2_first", int'(fm[0]), 3);

    sweep(0, ~golden(), 1'b0, lat);
    chk("s3_table", int'(tt[0]), 'h5808);
    chk("s3_ones", int'(ones[0]), 4);
    chk("s3_match", int'(match[0]), 0);
    chk("s3_first", int'(fm[0]), 0);

    fn[0] = golden();
    @(negedge clock);
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    wait_x(0, 4'd5);
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    wait_x(0, 4'd14);
    start[0] = 1'b1;
    wait_done(0, lat);
    chk("s4_table", int'(tt[0]), 'hA7F7);
    @(negedge clock);
    chk("s4_done_pulse", int'(done[0]), 0);
    chk("s4_idle_busy", int'(busy[0]), 0);
    @(negedge clock);
    chk("s4_rearm_busy", int'(busy[0]), 1);
    chk("s4_rearm_table", int'(tt[0]), 0);
    chk("s4_rearm_ones", int'(ones[0]), 0);
    start[0] = 1'b0;
    wait_done(0, lat);
    chk("s4_second_match", int'(match[0]), 1);

    @(negedge clock);
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    wait_x(0, 4'd7);
    reset_ = 1'b0;
    #1;
    chk("s5_busy", int'(busy[0]), 0);
    chk("s5_x", int'(xv[0]), 0);
    chk("s5_table", int'(tt[0]), 0);
    chk("s5_ones", int'(ones[0]), 0);
    @(negedge clock);
    reset_ = 1'b1;
    seen = 0;
    repeat (60) begin
      @(negedge clock);
      if (done[0]) seen = 1;
    end
    chk("s5_no_done", seen, 0);
    sweep(0, golden(), 1'b0, lat);
    chk("s5_table_after", int'(tt[0]), 'hA7F7);
    chk("s5_match_after", int'(match[0]), 1);

    sweep(1, golden(), 1'b0, lat);
    chk("s6_s0_lat", lat, 16);
    chk("s6_s0_table", int'(tt[1]), 'hA7F7);
    sweep(1, golden(), 1'b1, lat);
    chk("s6_s0_dly_match", int'(match[1]), 0);
    chk("s6_s0_dly_mv", int'(mv[1]), 1);
    sweep(2, golden(), 1'b1, lat);
    chk("s6_s1_dly_lat", lat, 32);
    chk("s6_s1_dly_match", int'(match[2]), 1);

    repeat (8) begin
      k = $urandom_range(0, 2);
      f = 16'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clock);
      sweep(k, f, 1'b0, lat);
      chk("rnd_table", int'(tt[k]), int'(f));
      chk("rnd_ones", int'(ones[k]), $countones(f));
      chk("rnd_lat", lat, 16 * (settle_of(k) + 1));
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
